regmem_xfer_unit: RTL and testbench
===================================

// Module: regmem_xfer_unit
// PURPOSE
//  Parametrised register file plus word-addressed data memory with a load/store transfer engine.
//  Successor to the fixed 32x32 regfile + 64-word RAM pair.
//  Adds configurable widths and depths, LOAD (mem->reg) and STORE (reg->mem) commands, a start/busy/done
//  handshake, misalignment rejection and write-port arbitration.
//  Sits between the datapath's register file access and its data memory.
// PARAMETERS
//  DATA_W     32  register/memory word width (bits)
//  REG_AW      5  register index width; 2**REG_AW registers
//  MEM_AW      6  memory word-address width; 2**MEM_AW words
//  ZERO_REG0   1  1: register 0 reads 0 and ignores all writes
// PORTS
//  Clk        in   1         clock, rising edge
//  Reset      in   1         asynchronous, active-low reset
//  R_Addr_A   in   REG_AW    read port A index
//  R_Addr_B   in   REG_AW    read port B index
//  R_Data_A   out  DATA_W    read port A data (combinational)
//  R_Data_B   out  DATA_W    read port B data (combinational)
//  Write_reg  in   1         external register write enable
//  W_Addr     in   REG_AW    external write index
//  W_Data     in   DATA_W    external write data
//  Start      in   1         command strobe, sampled only in IDLE
//  Op         in   2         01 STORE, 10 LOAD, 00/11 ignored
//  Mem_Addr   in   MEM_AW+2  byte address; [1:0] must be 00
//  Xfer_Reg   in   REG_AW    register sourced (STORE) or written (LOAD)
//  Mem_Dout   out  DATA_W    last word read by LOAD (registered)
//  Busy       out  1         high whenever state != IDLE
//  Done       out  1         one-cycle pulse in FIN
//  Err        out  1         one-cycle pulse: misaligned Start rejected
//  Wr_Drop    out  1         one-cycle pulse: external write lost to LOAD writeback
// BEHAVIOUR
//  Reset low (async): all registers 0; state IDLE; Mem_Dout=0; Busy=Done=Err=Wr_Drop=0.
//  Memory contents are not reset.
//  Reads: R_Data_x = reg[R_Addr_x], no write bypass; a write is visible the cycle after its edge.
//  ZERO_REG0=1: index 0 reads 0.
//  External write: reg[W_Addr] <= W_Data on edge when Write_reg=1, in any state except as below.
//  FSM states: IDLE, ST, LD_RD, LD_WB, FIN.
//  IDLE:
//   - Start=1, Op=01, Mem_Addr[1:0]=00: latch word addr = Mem_Addr[MEM_AW+1:2] and data = reg[Xfer_Reg]
//     (value before any same-edge write); -> ST.
//   - Start=1, Op=10, aligned: latch word addr and Xfer_Reg; -> LD_RD.
//   - Start=1, Op=01/10, Mem_Addr[1:0]!=00: stay IDLE; Err=1 for the next cycle.
//   - Op=00/11, or Start=0: stay IDLE, no pulse.
//  ST: mem[addr] <= latched data; -> FIN.
//  LD_RD: Mem_Dout <= mem[addr]; -> LD_WB.
//  LD_WB: reg[rd] <= Mem_Dout (suppressed if rd=0 and ZERO_REG0=1); -> FIN.
//   - Write_reg=1 on this edge: external write dropped (any W_Addr); Wr_Drop=1 next cycle.
//  FIN: Done=1; -> IDLE. A new Start is accepted only the cycle after FIN.
//  Latency from the accepting edge: STORE Done visible 2 cycles later, LOAD 3 cycles later.
//  Start while Busy=1 is ignored, with no pulse and no queuing.
//  Reset mid-operation aborts: a mem/reg write whose edge occurs while Reset=0 does not happen.
//  Mem_Dout holds its value until the next LOAD.
//  Address wrap: none needed; the word address covers exactly 2**MEM_AW words.
// TESTING
//  1 Reset low mid-LOAD, release -> Busy=0, Done=0, R_Data_A=0 for all indices, target reg unchanged(0).
//  2 Write r5=0xDEADBEEF; STORE Xfer_Reg=5, Mem_Addr=0x0C -> Done 2 cycles later;
//    LOAD Mem_Addr=0x0C into r7 -> r7=0xDEADBEEF, Mem_Dout=0xDEADBEEF.
//  3 STORE Mem_Addr=0x0E -> Err pulse one cycle, Busy stays 0, mem[3] unchanged.
//  4 LOAD into r9 with Write_reg=1, W_Addr=4 at LD_WB edge -> Wr_Drop pulse, r4 unchanged, r9 loaded.
//  5 Write r0=0x1234 and LOAD into r0 -> R_Data_A(r0)=0 always (ZERO_REG0=1).
//  6 Start pulsed every cycle during a LOAD -> exactly one Done; second command accepted only after FIN.

Source files
------------

// File: rtl/regmem_xfer_unit.sv
// Register file plus word-addressed data memory with a LOAD/STORE transfer engine.
// Two combinational read ports, one external write port, and a start/busy/done command handshake.
module regmem_xfer_unit #(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter int MEM_AW    = 6,
    parameter bit ZERO_REG0 = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [REG_AW-1:0] R_Addr_A,
    input  logic [REG_AW-1:0] R_Addr_B,
    output logic [DATA_W-1:0] R_Data_A,
    output logic [DATA_W-1:0] R_Data_B,
    input  logic              Write_reg,
    input  logic [REG_AW-1:0] W_Addr,
    input  logic [DATA_W-1:0] W_Data,
    input  logic              Start,
    input  logic [1:0]        Op,
    input  logic [MEM_AW+1:0] Mem_Addr,
    input  logic [REG_AW-1:0] Xfer_Reg,
    output logic [DATA_W-1:0] Mem_Dout,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic              Wr_Drop
);

    localparam int NREG = 1 << REG_AW;
    localparam int NMEM = 1 << MEM_AW;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ST    = 3'd1,
        S_LD_RD = 3'd2,
        S_LD_WB = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [MEM_AW-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [REG_AW-1:0]   rd_q, rd_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                drop_q, drop_d;

    logic [DATA_W-1:0]   regs_q [NREG];
    logic [DATA_W-1:0]   regs_d [NREG];
    logic [DATA_W-1:0]   mem [NMEM];
    logic                mem_we;
    logic [DATA_W-1:0]   xfer_val;
    logic                is_cmd;

    assign R_Data_A = (ZERO_REG0 && R_Addr_A == '0) ? '0 : regs_q[R_Addr_A];
    assign R_Data_B = (ZERO_REG0 && R_Addr_B == '0) ? '0 : regs_q[R_Addr_B];
    assign xfer_val = (ZERO_REG0 && Xfer_Reg == '0) ? '0 : regs_q[Xfer_Reg];
    assign is_cmd   = Start && (Op == 2'b01 || Op == 2'b10);

    assign Mem_Dout = dout_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Err      = err_q;
    assign Wr_Drop  = drop_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rd_d    = rd_q;
        dout_d  = dout_q;
        err_d   = 1'b0;
        drop_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (is_cmd) begin
                    if (Mem_Addr[1:0] != 2'b00) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d = Mem_Addr[MEM_AW+1:2];
                        if (Op == 2'b01) begin
                            data_d  = xfer_val;
                            state_d = S_ST;
                        end else begin
                            rd_d    = Xfer_Reg;
                            state_d = S_LD_RD;
                        end
                    end
                end
            end
            S_ST:    state_d = S_FIN;
            S_LD_RD: begin
                dout_d  = mem[addr_q];
                state_d = S_LD_WB;
            end
            S_LD_WB: begin
                // The writeback owns the only write port this cycle.
                drop_d  = Write_reg;
                state_d = S_FIN;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIN);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            rd_q    <= '0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (state_q == S_LD_WB) begin
            if (!(ZERO_REG0 && rd_q == '0)) regs_d[rd_q] = dout_q;
        end else if (Write_reg && !(ZERO_REG0 && W_Addr == '0)) begin
            regs_d[W_Addr] = W_Data;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Memory is not reset; the Reset gate keeps an aborted STORE from landing.
    assign mem_we = Reset && (state_q == S_ST);

    always_ff @(posedge Clk) begin
        if (mem_we) mem[addr_q] <= data_q;
    end

endmodule

// File: tb/tb_regmem_xfer_unit.sv
// Directed bench for regmem_xfer_unit: model-backed register/memory expectations and a
// scoreboard queue of LOAD results checked when Done arrives.
module tb_regmem_xfer_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [4:0]  R_Addr_A = '0, R_Addr_B = '0;
    logic [31:0] R_Data_A, R_Data_B;
    logic        Write_reg = 1'b0;
    logic [4:0]  W_Addr = '0;
    logic [31:0] W_Data = '0;
    logic        Start = 1'b0;
    logic [1:0]  Op = '0;
    logic [7:0]  Mem_Addr = '0;
    logic [4:0]  Xfer_Reg = '0;
    logic [31:0] Mem_Dout;
    logic        Busy, Done, Err, Wr_Drop;

    int total = 0;
    int bad   = 0;
    logic [31:0] sb_q [$];
    logic [31:0] mdl_mem [64];
    logic [31:0] mdl_reg [32];

    regmem_xfer_unit dut (
        .Clk(Clk), .Reset(Reset),
        .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
        .R_Data_A(R_Data_A), .R_Data_B(R_Data_B),
        .Write_reg(Write_reg), .W_Addr(W_Addr), .W_Data(W_Data),
        .Start(Start), .Op(Op), .Mem_Addr(Mem_Addr), .Xfer_Reg(Xfer_Reg),
        .Mem_Dout(Mem_Dout), .Busy(Busy), .Done(Done), .Err(Err), .Wr_Drop(Wr_Drop)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wreg(input logic [4:0] idx, input logic [31:0] val);
        Write_reg = 1'b1; W_Addr = idx; W_Data = val;
        tick();
        Write_reg = 1'b0;
        if (idx != 0) mdl_reg[idx] = val;
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] idx);
        R_Addr_A = idx; R_Addr_B = idx;
        #1;
        chk({tag, "_a"}, R_Data_A, mdl_reg[idx]);
        chk({tag, "_b"}, R_Data_B, mdl_reg[idx]);
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int lat = 1;
        while (Done !== 1'b1 && lat < 8) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
    endtask

    task automatic do_store(input string tag, input logic [7:0] addr, input logic [4:0] xr);
        Start = 1'b1; Op = 2'b01; Mem_Addr = addr; Xfer_Reg = xr;
        tick();
        Start = 1'b0; Op = 2'b00;
        chk({tag, "_busy"}, Busy, 1'b1);
        chk({tag, "_done_early"}, Done, 1'b0);
        wait_done(tag, 2);
        mdl_mem[addr[7:2]] = mdl_reg[xr];
        tick();
        chk({tag, "_idle"}, Busy, 1'b0);
    endtask

    task automatic do_load(input string tag, input logic [7:0] addr, input logic [4:0] rd,
                           input bit inject);
        int lat = 1;
        logic [31:0] exp;
        sb_q.push_back(mdl_mem[addr[7:2]]);
        Start = 1'b1; Op = 2'b10; Mem_Addr = addr; Xfer_Reg = rd;
        tick();
        Start = 1'b0; Op = 2'b00;
        while (Done !== 1'b1 && lat < 8) begin
            if (inject && lat == 2) begin
                Write_reg = 1'b1; W_Addr = 5'd4; W_Data = 32'h0BAD_0BAD;
            end
            tick();
            Write_reg = 1'b0;
            lat++;
        end
        chk({tag, "_lat"}, lat, 3);
        if (inject) chk({tag, "_wr_drop"}, Wr_Drop, 1'b1);
        exp = sb_q.pop_front();
        chk({tag, "_dout"}, Mem_Dout, exp);
        if (rd != 0) mdl_reg[rd] = exp;
        tick();
        chk({tag, "_idle"}, Busy, 1'b0);
        if (inject) chk({tag, "_drop_clr"}, Wr_Drop, 1'b0);
        chk_reg({tag, "_reg"}, rd);
    endtask

    initial begin
        int dones;
        logic [31:0] exp;
        for (int i = 0; i < 32; i++) mdl_reg[i] = '0;

        // Reset state
        tick(); tick();
        chk("rst_busy", Busy, 1'b0);
        chk("rst_done", Done, 1'b0);
        chk("rst_err", Err, 1'b0);
        chk("rst_drop", Wr_Drop, 1'b0);
        chk("rst_dout", Mem_Dout, 32'h0);
        Reset = 1'b1;
        tick();

        // 1: reset asserted during LD_WB aborts the writeback
        wreg(5'd3, 32'hA5A5_5A5A);
        do_store("st_w4", 8'h10, 5'd3);
        Start = 1'b1; Op = 2'b10; Mem_Addr = 8'h10; Xfer_Reg = 5'd6;
        tick();
        Start = 1'b0; Op = 2'b00;
        tick();
        Reset = 1'b0;
        #1;
        chk("abort_busy", Busy, 1'b0);
        chk("abort_done", Done, 1'b0);
        tick(); tick();
        Reset = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) mdl_reg[i] = '0;
        for (int i = 0; i < 32; i++) begin
            R_Addr_A = 5'(i);
            #1;
            chk($sformatf("abort_r%0d", i), R_Data_A, 32'h0);
        end
        chk("abort_dout", Mem_Dout, 32'h0);

        // 2: STORE then LOAD round trip
        wreg(5'd5, 32'hDEAD_BEEF);
        do_store("st_w3", 8'h0C, 5'd5);
        do_load("ld_r7", 8'h0C, 5'd7, 1'b0);

        // 3: misaligned commands and ignored opcodes
        wreg(5'd1, 32'h1111_1111);
        Start = 1'b1; Op = 2'b01; Mem_Addr = 8'h0E; Xfer_Reg = 5'd1;
        tick();
        Start = 1'b0; Op = 2'b00;
        chk("mis_st_err", Err, 1'b1);
        chk("mis_st_busy", Busy, 1'b0);
        tick();
        chk("mis_st_err_clr", Err, 1'b0);
        Start = 1'b1; Op = 2'b10; Mem_Addr = 8'h11; Xfer_Reg = 5'd2;
        tick();
        chk("mis_ld_err", Err, 1'b1);
        Op = 2'b00; Mem_Addr = 8'h0C;
        tick();
        chk("op00_busy", Busy, 1'b0);
        chk("op00_err", Err, 1'b0);
        Op = 2'b11;
        tick();
        Start = 1'b0; Op = 2'b00;
        chk("op11_busy", Busy, 1'b0);
        chk("op11_err", Err, 1'b0);
        do_load("ld_r8", 8'h0C, 5'd8, 1'b0);

        // 4: external write during LD_WB is dropped
        wreg(5'd4, 32'h4444_4444);
        do_load("ld_r9", 8'h10, 5'd9, 1'b1);
        chk_reg("r4_kept", 5'd4);

        // 5: register 0 is hardwired to zero
        wreg(5'd0, 32'h0000_1234);
        chk_reg("r0_wr", 5'd0);
        do_load("ld_r0", 8'h0C, 5'd0, 1'b0);

        // 6: Start held high through a LOAD; next command only after FIN
        sb_q.push_back(mdl_mem[3]);
        Start = 1'b1; Op = 2'b10; Mem_Addr = 8'h0C; Xfer_Reg = 5'd10;
        tick();
        Op = 2'b01; Mem_Addr = 8'h20; Xfer_Reg = 5'd5;
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (Done === 1'b1) dones++;
        end
        chk("hold_dones", dones, 1);
        chk("hold_gap_busy", Busy, 1'b0);
        exp = sb_q.pop_front();
        chk("hold_dout", Mem_Dout, exp);
        mdl_reg[10] = exp;
        chk_reg("hold_r10", 5'd10);
        tick();
        Start = 1'b0; Op = 2'b00;
        chk("hold_st_busy", Busy, 1'b1);
        wait_done("hold_st", 2);
        mdl_mem[8] = mdl_reg[5];
        tick();
        do_load("ld_r11", 8'h20, 5'd11, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
